display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexes the six 7-segment digits (HH:MM:SS) onto one shared segment bus plus six anode strobes.
- Sits between the time/adjust registers and the board pins. Consumes the BCD time vector and the one-hot adjust_mode from the mode controller.
- Blinks the field currently being adjusted. Inserts a dead-time between digit slots to suppress ghosting.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (>= 2).
- BLANK_CYCLES, 500, cycles at slot start with all anodes off (1 <= BLANK_CYCLES < SCAN_DIV).
- BLINK_FRAMES, 40, full frames per blink half-period (>= 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- digits_bcd  in  24  six BCD nibbles; [3:0] = seconds units (idx0) ... [23:20] = hours tens (idx5)
- adjust_mode  in  3  one-hot: 100 hours, 010 minutes, 001 seconds, 000 none
- dp_mask  in  6  decimal point enable per digit index
- seg_n  out  8  active-low segments; bit0=a ... bit6=g, bit7=dp
- an_n  out  6  active-low anode strobes; bit i = digit idx i
- frame_tick  out  1  one-cycle pulse per completed 6-digit frame

Behaviour:
- Reset (priority over everything):
  - slot counter = 0, digit idx = 0, frame counter = 0, blink phase = visible.
  - Captured digits/mode/dp = 0.
  - seg_n = 8'hFF, an_n = 6'h3F, frame_tick = 0.
- Slot counter cnt: 0..SCAN_DIV-1.
  - On terminal count: idx advances 0→1→…→5→0.
  - The 5→0 wrap raises frame_tick for exactly one cycle, coincident with the first blank output of idx0.
- Capture: digits_bcd, adjust_mode and dp_mask are latched only at frame start (idx=0, cnt=0). Mid-frame input changes have no effect until the next frame; no tearing.
- Outputs are registered with 1-cycle latency from the (idx, cnt) state:
  - cnt < BLANK_CYCLES: an_n = 3F, seg_n = FF.
  - Otherwise: an_n = ~(1<<idx), seg_n = ~{dp_cap[idx], decode(nibble idx)}.
- Decode: 0–9 use standard patterns. Nibbles A–F display "-" (g only, seg_n = 8'hBF with dp off).
- Field map: seconds = idx0,1; minutes = idx2,3; hours = idx4,5.
- Blink:
  - The frame counter counts frames 0..BLINK_FRAMES-1. On wrap it toggles the blink phase.
  - In the hidden phase, digits of the field selected by the captured adjust_mode are fully blanked for the whole slot: an_n = 3F, seg_n = FF. Slot timing is unchanged.
  - adjust_mode = 000 never blanks.
  - A non-one-hot adjust_mode is treated as 000.
- Mode change: when the captured adjust_mode differs from the previous capture, the frame counter resets to 0 and the phase forces visible in that same frame. The newly selected field appears immediately and stays visible for a full half-period.
- Reset mid-frame: the next frame starts cleanly at idx0 with blank dead-time. No partial anode pulse may follow reset deassertion.

Decomposition:
- Package clock_display_pkg:
  - NUM_DIGITS = 6.
  - Mode constants MODE_NONE / MODE_HOURS / MODE_MINUTES / MODE_SECONDS.
  - Segment pattern constants SEG_0..SEG_9, SEG_DASH (active-high gfedcba).
  - Field-to-digit-index mapping function.
- Sub-module seg7_decode: combinational 4-bit BCD → 7-bit active-high pattern, shareable with other display users.

Test Plan:
- Parameters for all scenarios: SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2.
- Reset/sequence: hold reset 3 cycles → an_n=3F, seg_n=FF. After release, an_n sampled after edges 1..8 = 3F,3E,3E,3E,3F,3D,3D,3D. frame_tick pulses once every 24 cycles.
- Decode: digits_bcd=24'h123456, adjust_mode=000, dp_mask=0 → idx0 seg_n=82 ('6'), idx1 seg_n=92 ('5'), idx5 seg_n=F9 ('1'). dp_mask=6'b000100 → idx2 seg_n[7]=0.
- Invalid BCD: digits_bcd[3:0]=4'hA → idx0 seg_n=BF. Change digits_bcd mid-frame → displayed values change only from the next frame.
- Blink: adjust_mode=010 → frames 0–1 idx2/3 lit. Frames 2–3 idx2/3 slots show an_n=3F, seg_n=FF for all 4 cycles. idx0,1,4,5 unaffected.
- Mode change: during a hidden minutes phase, switch to 100 → next frame hours visible for 2 frames then hidden. Minutes lit continuously.
- Reset mid-frame: assert reset during idx3 active slot → outputs 3F/FF next cycle. Restart reproduces the scenario-1 sequence exactly.

Source files
------------

// File: rtl/clock_display_pkg.sv
// Shared constants for the clock display path: digit count, one-hot adjust modes,
// active-high gfedcba segment patterns and the field-to-digit mapping.
package clock_display_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [2:0] MODE_NONE    = 3'b000;
  localparam logic [2:0] MODE_SECONDS = 3'b001;
  localparam logic [2:0] MODE_MINUTES = 3'b010;
  localparam logic [2:0] MODE_HOURS   = 3'b100;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Digit indices belonging to the selected field; anything not one-hot selects nothing.
  function automatic logic [NUM_DIGITS-1:0] field_digit_mask(input logic [2:0] mode);
    case (mode)
      MODE_HOURS:   return 6'b110000;
      MODE_MINUTES: return 6'b001100;
      MODE_SECONDS: return 6'b000011;
      default:      return 6'b000000;
    endcase
  endfunction

  function automatic logic [2:0] mode_normalize(input logic [2:0] mode);
    return (field_digit_mask(mode) != '0) ? mode : MODE_NONE;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high gfedcba pattern; non-decimal codes show a dash.
module seg7_decode
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: every path assigns seg (default arm included), so no latch is inferred.
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit multiplexed 7-segment scanner with per-slot dead-time, frame-start
// input capture and blinking of the field being adjusted.
module display_scan_ctrl
  import clock_display_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] digits_bcd,
  input  logic [2:0]  adjust_mode,
  input  logic [5:0]  dp_mask,
  output logic [7:0]  seg_n,
  output logic [5:0]  an_n,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [FRM_W-1:0] frame_cnt;
  logic             hidden;
  logic             wrap_pend;
  logic [23:0]      digits_cap;
  logic [2:0]       mode_cap;
  logic [5:0]       dp_cap;

  logic             slot_end;
  logic             frame_start;
  logic             frame_end;
  logic [2:0]       mode_next;
  logic [3:0]       nibble;
  logic [6:0]       pattern;
  logic [5:0]       field_mask;
  logic             slot_dark;

  assign slot_end    = (cnt == CNT_LAST);
  assign frame_start = (idx == 3'd0) && (cnt == '0);
  assign frame_end   = (idx == IDX_LAST) && slot_end;
  assign mode_next   = mode_normalize(adjust_mode);

  assign nibble     = digits_cap[{idx, 2'b00} +: 4];
  assign field_mask = field_digit_mask(mode_cap);
  assign slot_dark  = (cnt < CNT_BLANK) || (hidden && field_mask[idx]);

  seg7_decode u_decode (
    .bcd (nibble),
    .seg (pattern)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= 3'd0;
      frame_cnt  <= '0;
      hidden     <= 1'b0;
      wrap_pend  <= 1'b0;
      digits_cap <= '0;
      mode_cap   <= MODE_NONE;
      dp_cap     <= '0;
    end else begin
      wrap_pend <= frame_end;

      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // Capture happens only here so a frame never mixes old and new digits.
      if (frame_start) begin
        digits_cap <= digits_bcd;
        mode_cap   <= mode_next;
        dp_cap     <= dp_mask;
        if (mode_next != mode_cap) begin
          frame_cnt <= '0;
          hidden    <= 1'b0;
        end
      end else if (frame_end) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt <= '0;
          hidden    <= ~hidden;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end
    end
  end

  // Outputs lag the (idx, cnt) state by one cycle; the idx0 dead-time slot carries frame_tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n      <= 8'hFF;
      an_n       <= 6'h3F;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap_pend;
      if (slot_dark) begin
        an_n  <= 6'h3F;
        seg_n <= 8'hFF;
      end else begin
        an_n  <= ~(6'b000001 << idx);
        seg_n <= ~{dp_cap[idx], pattern};
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl against a frame/slot arithmetic model.
module tb_display_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int DIGITS       = 6;
  localparam int FRAME_LEN    = SCAN_DIV * DIGITS;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] digits_bcd = '0;
  logic [2:0]  adjust_mode = '0;
  logic [5:0]  dp_mask = '0;
  logic [7:0]  seg_n;
  logic [5:0]  an_n;
  logic        frame_tick;

  display_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits_bcd  (digits_bcd),
    .adjust_mode (adjust_mode),
    .dp_mask     (dp_mask),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model state: position since reset release, captured frame inputs, blink run origin.
  int          pos;
  int          run_start;
  logic [2:0]  prev_mode;
  logic [23:0] cap_d;
  logic [2:0]  cap_m;
  logic [5:0]  cap_dp;
  bit          hidden_m;
  logic [6:0]  pat_tbl [16];
  logic [5:0]  an_seq [8];

  function automatic logic [2:0] norm(input logic [2:0] m);
    return (m == 3'b001 || m == 3'b010 || m == 3'b100) ? m : 3'b000;
  endfunction

  task automatic reset_for(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      check("rst_an", 32'(an_n), 32'h3F);
      check("rst_seg", 32'(seg_n), 32'hFF);
      check("rst_tick", 32'(frame_tick), 32'h0);
    end
    reset = 1'b0;
    pos = 0;
    run_start = 0;
    prev_mode = 3'b000;
    cap_d = '0;
    cap_m = '0;
    cap_dp = '0;
    hidden_m = 1'b0;
  endtask

  task automatic step();
    int frame_no, slot, c, nib;
    bit dark, field_sel;
    logic [5:0] exp_an;
    logic [7:0] exp_seg;
    @(posedge clk); #1;
    frame_no = pos / FRAME_LEN;
    if (pos % FRAME_LEN == 0) begin
      cap_d  = digits_bcd;
      cap_m  = norm(adjust_mode);
      cap_dp = dp_mask;
      if (cap_m != prev_mode) begin
        run_start = frame_no;
        prev_mode = cap_m;
      end
      hidden_m = (((frame_no - run_start) / BLINK_FRAMES) % 2) == 1;
    end
    slot = (pos % FRAME_LEN) / SCAN_DIV;
    c    = pos % SCAN_DIV;
    field_sel = (cap_m == (3'b001 << (slot / 2)));
    dark = (c < BLANK_CYCLES) || (hidden_m && field_sel);
    nib  = int'((cap_d >> (4 * slot)) & 24'hF);
    if (dark) begin
      exp_an  = 6'h3F;
      exp_seg = 8'hFF;
    end else begin
      exp_an  = 6'h3F ^ 6'(1 << slot);
      exp_seg = ~{cap_dp[slot], pat_tbl[nib]};
    end
    check("an_n", 32'(an_n), 32'(exp_an));
    check("seg_n", 32'(seg_n), 32'(exp_seg));
    check("frame_tick", 32'(frame_tick), 32'((pos % FRAME_LEN == 0) && (pos >= FRAME_LEN)));
    if (pos < 8) check("an_seq", 32'(an_n), 32'(an_seq[pos]));
    pos++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    pat_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    an_seq  = '{6'h3F, 6'h3E, 6'h3E, 6'h3E, 6'h3F, 6'h3D, 6'h3D, 6'h3D};

    // Reset and basic decode of 12:34:56.
    digits_bcd = 24'h123456;
    reset_for(3);
    run(2 * FRAME_LEN);

    // Decimal point on idx2, then a non-decimal nibble on idx0.
    dp_mask = 6'b000100;
    run(FRAME_LEN);
    digits_bcd = 24'h12345A;
    run(FRAME_LEN);

    // Mid-frame change must wait for the next frame.
    run(10);
    digits_bcd = 24'h654321;
    dp_mask = 6'b100001;
    run(FRAME_LEN - 10 + FRAME_LEN);

    // Minutes blink, then switch to hours while minutes are hidden.
    adjust_mode = 3'b010;
    run(3 * FRAME_LEN);
    adjust_mode = 3'b100;
    run(5 * FRAME_LEN);

    // Reset during idx3 active time, then replay the opening scenario.
    run(14);
    digits_bcd = 24'h123456;
    adjust_mode = 3'b000;
    dp_mask = '0;
    reset_for(1);
    run(2 * FRAME_LEN);

    // Random inputs including non-one-hot modes and non-decimal nibbles.
    for (int i = 0; i < 30 * FRAME_LEN; i++) begin
      if ($urandom_range(0, 7) == 0) digits_bcd = 24'($urandom);
      if ($urandom_range(0, 7) == 0) dp_mask = 6'($urandom);
      if ($urandom_range(0, 39) == 0) adjust_mode = 3'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
